mdu_unit: RTL and testbench

- E-stage multiply/divide unit of the 5-stage MIPS pipeline.
- Consumes the E-stage MDU select code and the forwarded rs/rt operands.
- Owns the HI/LO registers and provides mfhi/mflo read data to the E→M pipeline register.
- Drives busy/start to the stall controller, which stalls any D-stage MDU instruction while a multiply or divide is in flight.

---
 rtl/mdu_unit.sv | 168 ++++++++++++++++
 tb/tb_mdu_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// -----------------------------------------------------------------------------
// mdu_unit -- E-stage multiply/divide unit of the 5-stage MIPS pipeline.
//
// Owns the architectural HI/LO registers. A mult/multu/div/divu accepted in
// the E stage has its 64-bit result computed at once and parked in tmp_hi /
// tmp_lo; the unit then stays busy for MULT_CYCLES or DIV_CYCLES cycles
// (modelling a multi-cycle datapath) before committing the result to HI/LO.
// The stall controller watches busy/start to hold later MDU instructions
// in D.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   E_sel_MDU  op code: 0 mult, 1 multu, 2 div, 3 divu, 4 mfhi, 5 mflo,
//              6 mthi, 7 mtlo, 8..15 none
//   E_A, E_B   forwarded rs / rt operands
//   req        exception/interrupt taken; squashes the E-stage MDU op
//   start      (comb) mult/multu/div/divu accepted this cycle
//   busy       (reg)  operation in flight
//   E_MDU_out  (comb) HI for mfhi, LO for mflo, else 0
//   HI, LO     architectural HI/LO registers
// -----------------------------------------------------------------------------
module mdu_unit #(
  parameter int MULT_CYCLES = 5,   // 1..15
  parameter int DIV_CYCLES  = 10   // 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  E_sel_MDU,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] E_MDU_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MFHI  = 4'd4;
  localparam logic [3:0] OP_MFLO  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd6;
  localparam logic [3:0] OP_MTLO  = 4'd7;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state, state_next;
  logic [3:0]  cnt;
  logic [31:0] tmp_hi, tmp_lo;
  logic        accept;
  logic [3:0]  cnt_load;

  // ---------------------------------------------------------------------------
  // Arithmetic
  // ---------------------------------------------------------------------------
  logic [63:0] prod_s, prod_u;
  logic        div_zero, div_ovf;
  logic [31:0] s_divisor, u_divisor;
  logic [31:0] s_quo, s_rem, u_quo, u_rem;
  logic [31:0] res_hi, res_lo;

  assign prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
  assign prod_u = {32'd0, E_A} * {32'd0, E_B};

  assign div_zero = (E_B == 32'd0);
  assign div_ovf  = (E_A == 32'h8000_0000) && (E_B == 32'hFFFF_FFFF);

  // The divider never sees 0 or the INT_MIN/-1 overflow pair: those cases are
  // resolved by the result mux, and a divisor of 1 keeps the operator defined
  // (no X in simulation, no trap in compiled models).
  assign s_divisor = (div_zero || div_ovf) ? 32'd1 : E_B;
  assign u_divisor = div_zero ? 32'd1 : E_B;

  assign s_quo = $signed(E_A) / $signed(s_divisor);   // truncates toward zero
  assign s_rem = $signed(E_A) % $signed(s_divisor);   // sign of dividend
  assign u_quo = E_A / u_divisor;
  assign u_rem = E_A % u_divisor;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    unique case (E_sel_MDU)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (div_zero)     {res_hi, res_lo} = {E_A, 32'hFFFF_FFFF};
        else if (div_ovf) {res_hi, res_lo} = {32'd0, 32'h8000_0000};
        else              {res_hi, res_lo} = {s_rem, s_quo};
      end
      OP_DIVU: begin
        if (div_zero)     {res_hi, res_lo} = {E_A, 32'hFFFF_FFFF};
        else              {res_hi, res_lo} = {u_rem, u_quo};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  assign accept   = (state == IDLE) && !req;
  assign start    = accept && (E_sel_MDU <= OP_DIVU);
  assign cnt_load = (E_sel_MDU == OP_MULT || E_sel_MDU == OP_MULTU)
                    ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);

  // Reads see the architectural registers, never the parked result.
  always_comb begin
    E_MDU_out = 32'd0;
    if (E_sel_MDU == OP_MFHI)      E_MDU_out = HI;
    else if (E_sel_MDU == OP_MFLO) E_MDU_out = LO;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (cnt == 4'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      cnt    <= 4'd0;
      tmp_hi <= 32'd0;
      tmp_lo <= 32'd0;
      HI     <= 32'd0;
      LO     <= 32'd0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (start) begin
            tmp_hi <= res_hi;
            tmp_lo <= res_lo;
            cnt    <= cnt_load;
            busy   <= 1'b1;
          end else if (accept && E_sel_MDU == OP_MTHI) begin
            HI <= E_A;
          end else if (accept && E_sel_MDU == OP_MTLO) begin
            LO <= E_A;
          end
        end
        BUSY: begin
          // Ops arriving now are ignored; only the countdown and commit run.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            HI   <= tmp_hi;
            LO   <= tmp_lo;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  E_sel_MDU;
  logic [31:0] E_A, E_B;
  logic        req;
  logic        start, busy;
  logic [31:0] E_MDU_out, HI, LO;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .E_sel_MDU(E_sel_MDU), .E_A(E_A), .E_B(E_B),
    .req(req), .start(start), .busy(busy), .E_MDU_out(E_MDU_out),
    .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive an op for one cycle, check start before the edge, then present
  // `sel_after` (with junk operands) for the following cycles.
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic r, input logic exp_start,
                       input logic [3:0] sel_after);
    @(posedge clk); #1;
    E_sel_MDU = op; E_A = a; E_B = b; req = r;
    @(negedge clk);
    check({tag, ".start"}, 32'(start), 32'(exp_start));
    @(posedge clk); #1;
    E_sel_MDU = sel_after; E_A = 32'hDEAD_BEEF; E_B = 32'h0000_0003; req = 1'b0;
  endtask

  // Count busy cycles (sampled at negedges, bounded) and compare the committed
  // HI/LO against the front of the scoreboard.
  task automatic wait_done();
    exp_t e;
    int   n = 0;
    bit   first = 1'b1;
    e = sb.pop_front();
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      if (first) check({e.tag, ".start_low_busy"}, 32'(start), 32'd0);
      first = 1'b0;
      n++;
    end
    E_sel_MDU = 4'd15;
    check({e.tag, ".busy_cycles"}, 32'(n), 32'(e.cycles));
    check({e.tag, ".HI"}, HI, e.hi);
    check({e.tag, ".LO"}, LO, e.lo);
  endtask

  initial begin
    rst_n = 1'b0; E_sel_MDU = 4'd15; E_A = '0; E_B = '0; req = 1'b0;
    #12;
    check("reset.HI", HI, 32'd0);
    check("reset.LO", LO, 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // mult -3*5; a mthi presented while busy must be ignored
    sb.push_back('{"mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5});
    issue("mult", 4'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1, 4'd6);
    wait_done();

    // restarts attempted while busy must be ignored too
    sb.push_back('{"divu", 32'd1, 32'd3, 10});
    issue("divu", 4'd3, 32'd7, 32'd2, 1'b0, 1'b1, 4'd0);
    wait_done();

    sb.push_back('{"div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
    issue("div_neg", 4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 4'd15);
    wait_done();

    sb.push_back('{"div_by0", 32'd9, 32'hFFFF_FFFF, 10});
    issue("div_by0", 4'd2, 32'd9, 32'd0, 1'b0, 1'b1, 4'd15);
    wait_done();

    sb.push_back('{"divu_by0", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 10});
    issue("divu_by0", 4'd3, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b1, 4'd15);
    wait_done();

    sb.push_back('{"div_ovf", 32'd0, 32'h8000_0000, 10});
    issue("div_ovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd15);
    wait_done();

    // same operands as unsigned: quotient 0, remainder = dividend
    sb.push_back('{"divu_big", 32'h8000_0000, 32'd0, 10});
    issue("divu_big", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd15);
    wait_done();

    sb.push_back('{"multu", 32'hFFFF_FFFE, 32'h0000_0001, 5});
    issue("multu", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd15);
    wait_done();

    // mthi/mflo/mtlo/mfhi and the "none" code
    issue("mthi", 4'd6, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 4'd4);
    @(negedge clk); check("mfhi", E_MDU_out, 32'h1234_5678);
    issue("mtlo", 4'd7, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0, 4'd5);
    @(negedge clk); check("mflo", E_MDU_out, 32'h9ABC_DEF0);
    E_sel_MDU = 4'd15;
    #1 check("none_out", E_MDU_out, 32'd0);

    // req squashes multu and mthi
    issue("multu_req", 4'd1, 32'd100, 32'd100, 1'b1, 1'b0, 4'd15);
    @(negedge clk);
    check("multu_req.busy", 32'(busy), 32'd0);
    check("multu_req.HI", HI, 32'h1234_5678);
    check("multu_req.LO", LO, 32'h9ABC_DEF0);
    issue("mthi_req", 4'd6, 32'h5555_5555, 32'd0, 1'b1, 1'b0, 4'd15);
    @(negedge clk);
    check("mthi_req.HI", HI, 32'h1234_5678);

    // req while busy does not abort the operation
    sb.push_back('{"mult_req_busy", 32'd0, 32'd6, 5});
    issue("mult_req_busy", 4'd0, 32'd2, 32'd3, 1'b0, 1'b1, 4'd15);
    req = 1'b1;
    wait_done();
    req = 1'b0;

    // async reset in cycle 3 of a div: result discarded, no later commit
    issue("div_rst", 4'd2, 32'd100, 32'd7, 1'b0, 1'b1, 4'd15);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("div_rst.busy", 32'(busy), 32'd0);
    check("div_rst.HI", HI, 32'd0);
    check("div_rst.LO", LO, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("div_rst.late_busy", 32'(busy), 32'd0);
    check("div_rst.late_HI", HI, 32'd0);
    check("div_rst.late_LO", LO, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
